// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge capture, mask, fixed priority, req/ack/ret handshake.
// Define INTR_SYNC_EN to place a 2-flop synchronizer in front of edge detection.
module intr_ctrl #(
  parameter int unsigned      N_IRQ      = 8,
  parameter logic [N_IRQ-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             intr_ack,
  input  logic             intr_ret,
  output logic [N_IRQ-1:0] intr,
  output logic             intr_req,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_e;

  localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] grant_q;
  logic [N_IRQ-1:0] intr_q;
  logic             req_q;
  logic [N_IRQ-1:0] in_service_q;
  logic [N_IRQ-1:0] set;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] lowest;

`ifdef INTR_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // set is OR-ed after the clear, so a same-cycle edge survives the ack
  always_comb begin
    set       = irq_s & ~irq_prev_q;
    clr       = '0;
    if (state_q == REQUEST && intr_ack)
      clr     = grant_q;
    pending_d = (pending_q & ~clr) | set;
    eligible  = pending_q & mask_q;
    lowest    = eligible & (~eligible + ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= RESET_MASK;
      grant_q      <= '0;
      intr_q       <= '0;
      req_q        <= 1'b0;
      in_service_q <= '0;
    end else begin
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      if (mask_we)
        mask_q <= mask_in;
      unique case (state_q)
        IDLE: begin
          if (|eligible) begin
            grant_q <= lowest;
            intr_q  <= lowest;
            req_q   <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          if (intr_ack) begin
            intr_q       <= '0;
            req_q        <= 1'b0;
            in_service_q <= grant_q;
            state_q      <= SERVICE;
          end
        end
        SERVICE: begin
          if (intr_ret) begin
            in_service_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign intr       = intr_q;
  assign intr_req   = req_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios then random traffic,
// each cycle checked against a behavioural model of the controller.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_in = '0;
  logic       intr_ack = 1'b0;
  logic       intr_ret = 1'b0;
  logic [7:0] intr;
  logic       intr_req;
  logic [7:0] in_service;
  logic [7:0] pending;

  localparam logic [7:0] RST_MASK = 8'h00;

  intr_ctrl #(.N_IRQ(8), .RESET_MASK(RST_MASK)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .intr_ack   (intr_ack),
    .intr_ret   (intr_ret),
    .intr       (intr),
    .intr_req   (intr_req),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] intr;
    logic       req;
    logic [7:0] isv;
    logic [7:0] pend;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // model: mode 0 idle, 1 waiting for ack, 2 in service
  int         m_mode = 0;
  int         m_line = -1;
  logic [7:0] m_pend = '0;
  logic [7:0] m_mask = '0;
  logic [7:0] m_prev = '0;
  logic [7:0] m_s1 = '0;
  logic [7:0] m_s2 = '0;
  logic [7:0] cur = '0;

  task automatic model(input logic r, input logic [7:0] irq,
                       input logic mwe, input logic [7:0] mv,
                       input logic ack, input logic ret);
    logic [7:0] src;
    logic [7:0] nxt;
    int         cl;
    bit         found;
    if (r) begin
      m_mode = 0; m_line = -1; m_pend = '0; m_mask = RST_MASK;
      m_prev = '0; m_s1 = '0; m_s2 = '0;
      return;
    end
`ifdef INTR_SYNC_EN
    src = m_s2;
`else
    src = irq;
`endif
    cl = (m_mode == 1 && ack) ? m_line : -1;
    for (int i = 0; i < 8; i++) begin
      if (src[i] && !m_prev[i]) nxt[i] = 1'b1;
      else if (i == cl)         nxt[i] = 1'b0;
      else                      nxt[i] = m_pend[i];
    end
    case (m_mode)
      0: begin
        found = 0;
        for (int i = 0; i < 8; i++)
          if (!found && m_pend[i] && m_mask[i]) begin
            found = 1; m_line = i; m_mode = 1;
          end
      end
      1: if (ack) m_mode = 2;
      2: if (ret) begin m_mode = 0; m_line = -1; end
      default: m_mode = 0;
    endcase
    m_pend = nxt;
    if (mwe) m_mask = mv;
    m_prev = src;
    m_s2 = m_s1;
    m_s1 = irq;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.intr = (m_mode == 1) ? 8'(1 << m_line) : 8'h00;
    e.req  = (m_mode == 1);
    e.isv  = (m_mode == 2) ? 8'(1 << m_line) : 8'h00;
    e.pend = m_pend;
    return e;
  endfunction

  task automatic step(input logic r, input logic [7:0] irq,
                      input logic mwe, input logic [7:0] mv,
                      input logic ack, input logic ret);
    @(negedge clk);
    reset = r; irq_in = irq; mask_we = mwe; mask_in = mv;
    intr_ack = ack; intr_ret = ret;
    cur = irq;
    model(r, irq, mwe, mv, ack, ret);
    sbq.push_back(predict());
  endtask

  task automatic cyc(input logic [7:0] irq, input logic ack, input logic ret);
    step(1'b0, irq, 1'b0, 8'h00, ack, ret);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) cyc(cur, 1'b0, 1'b0);
  endtask

  task automatic wmask(input logic [7:0] v);
    step(1'b0, cur, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("intr", intr, e.intr);
      cmp("intr_req", {7'd0, intr_req}, {7'd0, e.req});
      cmp("in_service", in_service, e.isv);
      cmp("pending", pending, e.pend);
    end
  end

  initial begin
    // basic request
    do_rst();
    wmask(8'hFF);
    cyc(8'h08, 0, 0); cyc(8'h00, 0, 0); hold(2);
    cyc(8'h00, 1, 0); hold(1); cyc(8'h00, 0, 1); hold(2);
    // priority
    cyc(8'h22, 0, 0); cyc(8'h00, 0, 0); hold(1);
    cyc(8'h00, 1, 0); hold(2); cyc(8'h00, 0, 1); hold(3);
    cyc(8'h00, 1, 0); cyc(8'h00, 0, 1); hold(1);
    // masking
    wmask(8'h00);
    cyc(8'h01, 0, 0); cyc(8'h00, 0, 0); hold(10);
    wmask(8'h01); hold(3);
    cyc(8'h00, 1, 0); cyc(8'h00, 0, 1); hold(1);
    // no preemption, no level retrigger
    wmask(8'hFF);
    cyc(8'h10, 0, 0); cyc(8'h00, 0, 0); hold(1);
    cyc(8'h00, 1, 0); hold(1);
    cyc(8'h01, 0, 0); hold(19);
    cyc(8'h01, 0, 1); hold(3);
    cyc(8'h01, 1, 0); cyc(8'h01, 0, 1); hold(5);
    cyc(8'h00, 0, 0); hold(2);
    // reset mid-request, then stray ack and masked-by-reset pulse
    cyc(8'h04, 0, 0); cyc(8'h00, 0, 0); hold(1);
    do_rst();
    cyc(8'h00, 1, 0); cyc(8'h00, 0, 1);
    cyc(8'h40, 0, 0); cyc(8'h00, 0, 0); hold(3);
    // set/clear collision; ack+ret together honours ack only
    do_rst();
    wmask(8'hFF);
    cyc(8'h02, 0, 0); cyc(8'h00, 0, 0); hold(1);
    cyc(8'h02, 1, 1); cyc(8'h00, 0, 0); hold(2);
    cyc(8'h00, 0, 1); hold(3);
    cyc(8'h00, 1, 0); cyc(8'h00, 0, 1); hold(2);
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] nirq;
      logic r, mwe, ack, ret;
      nirq = cur ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r    = ($urandom_range(0, 199) == 0);
      mwe  = ($urandom_range(0, 19) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      ret  = ($urandom_range(0, 3) == 0);
      step(r, nirq, mwe, 8'($urandom), ack, ret);
    end
    @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0 entries left", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
